// File: rtl/bp_io_reg_responder.sv
// bp_io_reg_responder
// Endpoint on the IO mem link. It answers uncached BedRock reads and
// byte-masked writes with a small array of 64-bit registers, and returns
// exactly one response per accepted command.
//
// Ports:
//   clk_i, reset_n_i              clock; asynchronous active-low reset
//   mem_cmd_*                     command channel (valid / yumi handshake)
//   mem_resp_*                    response channel (valid / ready handshake);
//                                 every output is driven from a register
//   err_count_o                   saturating count of accepted error commands
//
// A response is held in the output register. While that response is stalled
// (ready low), no new command is accepted. When a response transfers, a new
// command can be accepted on the same edge, so there is no bubble.
module bp_io_reg_responder #(
    parameter int                       paddr_width_p   = 40,
    parameter int                       payload_width_p = 16,
    parameter int                       els_p           = 16,
    parameter logic [paddr_width_p-1:0] base_addr_p     = 40'h00_0020_0000
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_yumi_o,
    input  logic [3:0]                 mem_cmd_type_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [63:0]                mem_cmd_data_i,

    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_ready_i,
    output logic [3:0]                 mem_resp_type_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [63:0]                mem_resp_data_o,
    output logic                       mem_resp_err_o,

    output logic [7:0]                 err_count_o
);

    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [paddr_width_p:0] base_ext_lp = {1'b0, base_addr_p};
    localparam logic [paddr_width_p:0] end_ext_lp  =
        base_ext_lp + (paddr_width_p + 1)'(els_p * 8);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Bytes covered by an access of 2^size bytes at the given offset.
    function automatic logic [7:0] size_byte_mask(input logic [2:0] size,
                                                  input logic [2:0] offset);
        logic [7:0] base_v;
        case (size)
            3'd0:    base_v = 8'h01;
            3'd1:    base_v = 8'h03;
            3'd2:    base_v = 8'h0F;
            3'd3:    base_v = 8'hFF;
            default: base_v = 8'h00;
        endcase
        return base_v << offset;
    endfunction

    // Widen a byte mask to a bit mask.
    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] out_v;
        for (int i = 0; i < 8; i++) begin
            out_v[8*i +: 8] = {8{m[i]}};
        end
        return out_v;
    endfunction

    // Replicate the low 2^size bytes to fill 64 bits.
    function automatic logic [63:0] replicate(input logic [63:0] v,
                                              input logic [2:0]  size);
        logic [63:0] out_v;
        case (size)
            3'd0:    out_v = {8{v[7:0]}};
            3'd1:    out_v = {4{v[15:0]}};
            3'd2:    out_v = {2{v[31:0]}};
            3'd3:    out_v = v;
            default: out_v = 64'd0;
        endcase
        return out_v;
    endfunction

    state_t state_r;
    state_t state_s;

    logic [63:0]                regs_r [els_p];
    logic [7:0]                 err_count_r;
    logic [3:0]                 resp_type_r;
    logic [paddr_width_p-1:0]   resp_addr_r;
    logic [2:0]                 resp_size_r;
    logic [payload_width_p-1:0] resp_payload_r;
    logic [63:0]                resp_data_r;
    logic                       resp_err_r;

    logic                accept_s;
    logic                is_rd_s;
    logic                is_wr_s;
    logic                in_range_s;
    logic                misaligned_s;
    logic                err_s;
    logic [2:0]          offset_s;
    logic [5:0]          shamt_s;
    logic [idx_w_lp-1:0] idx_s;
    logic [63:0]         rd_word_s;
    logic [63:0]         rd_data_s;
    logic [63:0]         wr_mask_s;
    logic [63:0]         wr_merge_s;
    logic [63:0]         resp_data_s;

    // Handshake: accept when nothing is held, or when the held response leaves
    // this cycle. Gating with reset keeps yumi low while reset is asserted.
    always_comb begin
        accept_s = mem_cmd_v_i & reset_n_i
                 & ((state_r == ST_IDLE) | mem_resp_ready_i);
        mem_cmd_yumi_o = accept_s;
    end

    // Command decode, error classification and read/write data paths.
    always_comb begin
        is_rd_s    = (mem_cmd_type_i == 4'h0);
        is_wr_s    = (mem_cmd_type_i == 4'h1);
        in_range_s = ({1'b0, mem_cmd_addr_i} >= base_ext_lp)
                   & ({1'b0, mem_cmd_addr_i} <  end_ext_lp);
        offset_s   = mem_cmd_addr_i[2:0];
        shamt_s    = {offset_s, 3'b000};
        idx_s      = mem_cmd_addr_i[3 +: idx_w_lp];

        case (mem_cmd_size_i)
            3'd0:    misaligned_s = 1'b0;
            3'd1:    misaligned_s = mem_cmd_addr_i[0];
            3'd2:    misaligned_s = |mem_cmd_addr_i[1:0];
            3'd3:    misaligned_s = |mem_cmd_addr_i[2:0];
            default: misaligned_s = 1'b0; // oversize is flagged separately
        endcase

        err_s = ~(is_rd_s | is_wr_s) | ~in_range_s
              | (mem_cmd_size_i > 3'd3) | misaligned_s;

        // The index is always a legal array index (els_p is a power of two);
        // the value is discarded when the address is out of range.
        rd_word_s   = regs_r[idx_s];
        rd_data_s   = replicate(rd_word_s >> shamt_s, mem_cmd_size_i);
        wr_mask_s   = expand_mask(size_byte_mask(mem_cmd_size_i, offset_s));
        wr_merge_s  = (rd_word_s & ~wr_mask_s)
                    | ((mem_cmd_data_i << shamt_s) & wr_mask_s);
        resp_data_s = (is_rd_s & ~err_s) ? rd_data_s : 64'd0;
    end

    // Next-state logic: a fresh accept always leaves a response held.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (accept_s) begin
                    state_s = ST_RESP;
                end else if (mem_resp_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Response register: loaded with the command echo and result on accept.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_type_r    <= 4'h0;
            resp_addr_r    <= '0;
            resp_size_r    <= 3'd0;
            resp_payload_r <= '0;
            resp_data_r    <= 64'd0;
            resp_err_r     <= 1'b0;
        end else if (accept_s) begin
            resp_type_r    <= mem_cmd_type_i;
            resp_addr_r    <= mem_cmd_addr_i;
            resp_size_r    <= mem_cmd_size_i;
            resp_payload_r <= mem_cmd_payload_i;
            resp_data_r    <= resp_data_s;
            resp_err_r     <= err_s;
        end else begin
            resp_type_r    <= resp_type_r;
            resp_addr_r    <= resp_addr_r;
            resp_size_r    <= resp_size_r;
            resp_payload_r <= resp_payload_r;
            resp_data_r    <= resp_data_r;
            resp_err_r     <= resp_err_r;
        end
    end

    // Register array: a byte-merged update on an accepted, error-free write.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                regs_r[i] <= 64'd0;
            end
        end else if (accept_s & is_wr_s & ~err_s) begin
            regs_r[idx_s] <= wr_merge_s;
        end else begin
            regs_r[idx_s] <= regs_r[idx_s];
        end
    end

    // Saturating count of accepted error commands.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_count_r <= 8'h00;
        end else if (accept_s & err_s & (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign mem_resp_v_o       = (state_r == ST_RESP);
    assign mem_resp_type_o    = resp_type_r;
    assign mem_resp_addr_o    = resp_addr_r;
    assign mem_resp_size_o    = resp_size_r;
    assign mem_resp_payload_o = resp_payload_r;
    assign mem_resp_data_o    = resp_data_r;
    assign mem_resp_err_o     = resp_err_r;
    assign err_count_o        = err_count_r;

endmodule

// File: tb/tb_bp_io_reg_responder.sv
// Self-checking bench for bp_io_reg_responder. A table of commands with
// expected results is applied back to back. Expected responses go into a
// scoreboard queue on accept and are compared when the response transfers.
// Separate sequences cover backpressure, error-count saturation and reset
// while a response is held.
module tb_bp_io_reg_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_v;
    logic        cmd_yumi;
    logic [3:0]  cmd_type;
    logic [39:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [15:0] cmd_payload;
    logic [63:0] cmd_data;
    logic        resp_v;
    logic        resp_ready;
    logic [3:0]  resp_type;
    logic [39:0] resp_addr;
    logic [2:0]  resp_size;
    logic [15:0] resp_payload;
    logic [63:0] resp_data;
    logic        resp_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    bp_io_reg_responder dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .mem_cmd_v_i        (cmd_v),
        .mem_cmd_yumi_o     (cmd_yumi),
        .mem_cmd_type_i     (cmd_type),
        .mem_cmd_addr_i     (cmd_addr),
        .mem_cmd_size_i     (cmd_size),
        .mem_cmd_payload_i  (cmd_payload),
        .mem_cmd_data_i     (cmd_data),
        .mem_resp_v_o       (resp_v),
        .mem_resp_ready_i   (resp_ready),
        .mem_resp_type_o    (resp_type),
        .mem_resp_addr_o    (resp_addr),
        .mem_resp_size_o    (resp_size),
        .mem_resp_payload_o (resp_payload),
        .mem_resp_data_o    (resp_data),
        .mem_resp_err_o     (resp_err),
        .err_count_o        (err_count)
    );

    typedef struct {
        logic [3:0]  typ;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [15:0] payload;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [3:0]  typ;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [15:0] payload;
        logic [63:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    acc_cyc_q[$];
    resp_t cur_exp;
    vec_t  vt[16];
    int    n_vec = 0;
    int    n_mis = 0;
    int    cyc = 0;
    int    n_pop = 0;
    logic  acc_flag;
    logic  lat_chk;

    function automatic resp_t resp_now();
        return {resp_type, resp_addr, resp_size, resp_payload, resp_data, resp_err};
    endfunction

    function automatic resp_t resp_of(input vec_t v);
        return {v.typ, v.addr, v.size, v.payload, v.exp_data, v.exp_err};
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic cycle();
        resp_t e;
        int    ac;
        @(negedge clk);
        if (resp_v && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 128'(resp_now()), 128'd0);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_cyc_q.pop_front();
                n_pop++;
                check("resp", 128'(resp_now()), 128'(e));
                if (lat_chk) begin
                    check("latency", 128'(cyc - ac), 128'd1);
                end
            end
        end
        acc_flag = 1'b0;
        if (cmd_yumi) begin
            exp_q.push_back(cur_exp);
            acc_cyc_q.push_back(cyc);
            acc_flag = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cmd_v       = 1'b1;
        cmd_type    = v.typ;
        cmd_addr    = v.addr;
        cmd_size    = v.size;
        cmd_data    = v.data;
        cmd_payload = v.payload;
        cur_exp     = resp_of(v);
    endtask

    task automatic send(input vec_t v);
        drive(v);
        acc_flag = 1'b0;
        for (int k = 0; k < 20 && !acc_flag; k++) begin
            cycle();
        end
        if (!acc_flag) begin
            check("accept_timeout", 128'd0, 128'd1);
        end
    endtask

    task automatic idle();
        cmd_v = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            cycle();
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        vec_t v;
        vec_t b0, b1, b2;
        resp_t held;
        int   yumi_cnt;
        int   pops0;

        vt[0]  = '{4'h1, 40'h20_0008, 3'd3, 64'h1122_3344_5566_7788, 16'h0001, 64'h0, 1'b0};
        vt[1]  = '{4'h0, 40'h20_0008, 3'd3, 64'h0, 16'h0002, 64'h1122_3344_5566_7788, 1'b0};
        vt[2]  = '{4'h1, 40'h20_000A, 3'd1, 64'hBEEF, 16'h0003, 64'h0, 1'b0};
        vt[3]  = '{4'h0, 40'h20_000A, 3'd1, 64'h0, 16'h0004, 64'hBEEF_BEEF_BEEF_BEEF, 1'b0};
        vt[4]  = '{4'h0, 40'h20_0008, 3'd3, 64'h0, 16'h0005, 64'h1122_3344_BEEF_7788, 1'b0};
        vt[5]  = '{4'h0, 40'h20_0080, 3'd3, 64'h0, 16'h0006, 64'h0, 1'b1};
        vt[6]  = '{4'h1, 40'h20_0001, 3'd2, 64'hFFFF_FFFF, 16'h0007, 64'h0, 1'b1};
        vt[7]  = '{4'h5, 40'h20_0008, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0008, 64'h0, 1'b1};
        vt[8]  = '{4'h0, 40'h20_0008, 3'd4, 64'h0, 16'h0009, 64'h0, 1'b1};
        vt[9]  = '{4'h0, 40'h20_0008, 3'd3, 64'h0, 16'h000A, 64'h1122_3344_BEEF_7788, 1'b0};
        vt[10] = '{4'h1, 40'h20_000F, 3'd0, 64'hA5, 16'h000B, 64'h0, 1'b0};
        vt[11] = '{4'h0, 40'h20_000F, 3'd0, 64'h0, 16'h000C, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0};
        vt[12] = '{4'h0, 40'h20_000C, 3'd2, 64'h0, 16'h000D, 64'hA522_3344_A522_3344, 1'b0};
        vt[13] = '{4'h1, 40'h20_0078, 3'd3, 64'hCAFE_F00D_DEAD_BEEF, 16'h000E, 64'h0, 1'b0};
        vt[14] = '{4'h0, 40'h20_0078, 3'd2, 64'h0, 16'h000F, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0};
        vt[15] = '{4'h0, 40'h20_0000, 3'd3, 64'h0, 16'h0010, 64'h0, 1'b0};

        // Reset, with a command presented so yumi-in-reset is observable.
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        lat_chk    = 1'b1;
        drive(vt[1]);
        #2;
        check("reset_yumi", 128'(cmd_yumi), 128'd0);
        check("reset_resp_v", 128'(resp_v), 128'd0);
        check("reset_fields", 128'(resp_now()), 128'd0);
        check("reset_err_count", 128'(err_count), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: applied back to back with ready held high.
        for (int i = 0; i < 10; i++) begin
            send(vt[i]);
        end
        idle();
        drain();
        check("err_count_4", 128'(err_count), 128'd4);
        for (int i = 10; i < 16; i++) begin
            send(vt[i]);
        end
        idle();
        drain();

        // Backpressure: first read accepted, then 4 stalled cycles.
        lat_chk = 1'b0;
        b0 = '{4'h0, 40'h20_0008, 3'd3, 64'h0, 16'h00B0, 64'hA522_3344_BEEF_7788, 1'b0};
        b1 = '{4'h0, 40'h20_0078, 3'd3, 64'h0, 16'h00B1, 64'hCAFE_F00D_DEAD_BEEF, 1'b0};
        b2 = '{4'h0, 40'h20_0000, 3'd3, 64'h0, 16'h00B2, 64'h0, 1'b0};
        resp_ready = 1'b0;
        send(b0);
        drive(b1);
        held = resp_of(b0);
        yumi_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cmd_yumi) begin
                yumi_cnt++;
            end
            check("stall_v", 128'(resp_v), 128'd1);
            check("stall_hold", 128'(resp_now()), 128'(held));
            cyc++;
            @(posedge clk);
            #1;
        end
        check("stall_yumi", 128'(yumi_cnt), 128'd0);
        resp_ready = 1'b1;
        pops0 = n_pop;
        send(b1);
        send(b2);
        idle();
        cycle();
        check("bp_consecutive", 128'(n_pop - pops0), 128'd3);
        drain();

        // Below-base access is an error, then saturate the counter.
        v = '{4'h0, 40'h1F_FFF8, 3'd3, 64'h0, 16'h00C0, 64'h0, 1'b1};
        send(v);
        idle();
        drain();
        check("err_count_5", 128'(err_count), 128'd5);
        for (int i = 0; i < 260; i++) begin
            v = '{4'h5, 40'h20_0008, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 16'(i), 64'h0, 1'b1};
            send(v);
        end
        idle();
        drain();
        check("err_count_sat", 128'(err_count), 128'hFF);
        check("err_no_write_rd", 128'(dut.regs_r[1]), 128'(64'hA522_3344_BEEF_7788));

        // Reset between edges while a response is stalled.
        resp_ready = 1'b0;
        v = '{4'h0, 40'h20_0008, 3'd3, 64'h0, 16'h00D0, 64'hA522_3344_BEEF_7788, 1'b0};
        send(v);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_v", 128'(resp_v), 128'd0);
        check("rst_mid_yumi", 128'(cmd_yumi), 128'd0);
        check("rst_mid_fields", 128'(resp_now()), 128'd0);
        check("rst_mid_err_count", 128'(err_count), 128'd0);
        exp_q.delete();
        acc_cyc_q.delete();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        repeat (3) cycle();
        check("post_rst_quiet", 128'(resp_v), 128'd0);
        lat_chk = 1'b1;
        v = '{4'h0, 40'h20_0008, 3'd3, 64'h0, 16'h00D1, 64'h0, 1'b0};
        send(v);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
